hp_controller: RTL and testbench

- Owns the player HP value that the HP bar renderer draws. It is the writer side of the 10-bit `hp` bus.
- Applies damage on soul/bullet collision and grants invincibility frames after each hit.
- Applies heal requests, flags death, and restores full HP on restart.
- Sits between the collision logic, the game-state FSM and the HP bar sprite.

---
 rtl/hp_controller.sv | 135 +++++++++++++
 tb/tb_hp_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hp_controller.sv
// hp_controller: owns the player HP value drawn by the HP bar renderer.
//
// Applies damage when the soul overlaps a bullet, then grants a window of
// invincibility frames. Applies heal requests, flags death at zero HP and
// restores full HP on restart. All outputs are registered or decoded
// directly from registered state (1-cycle latency from sampled inputs).
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   state      in   [3:0] game state; 1 and 2 are battle states
//   frame_tick in   one-cycle pulse per video frame
//   hit        in   level; soul overlaps a bullet this cycle
//   heal_req   in   one-cycle heal pulse
//   restart    in   one-cycle pulse; restore full HP (works in any state)
//   hp         out  [9:0] current HP, 0..HP_MAX
//   dead       out  high while in DEAD
//   invuln     out  high while in INVULN (drives soul blinking)
//   hit_ack    out  one-cycle pulse when a hit is accepted
module hp_controller #(
    parameter logic [9:0] HP_MAX       = 10'd200,
    parameter logic [9:0] HIT_DAMAGE   = 10'd20,
    parameter logic [9:0] HEAL_AMOUNT  = 10'd40,
    parameter logic [6:0] IFRAME_TICKS = 7'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       heal_req,
    input  logic       restart,
    output logic [9:0] hp,
    output logic       dead,
    output logic       invuln,
    output logic       hit_ack
);

    localparam logic [1:0] ST_ALIVE  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    logic [1:0]  fsm_q, fsm_d;
    logic [9:0]  hp_q, hp_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;

    logic        battle;
    logic [9:0]  hp_damaged;
    logic [10:0] hp_sum;
    logic [9:0]  hp_healed;

    assign battle = (state == 4'd1) || (state == 4'd2);

    // Saturating subtract: never wraps below zero.
    assign hp_damaged = (hp_q > HIT_DAMAGE) ? (hp_q - HIT_DAMAGE) : 10'd0;

    // Sum at 11 bits so hp + HEAL_AMOUNT cannot overflow before the clamp.
    assign hp_sum    = {1'b0, hp_q} + {1'b0, HEAL_AMOUNT};
    assign hp_healed = (hp_sum >= {1'b0, HP_MAX}) ? HP_MAX : hp_sum[9:0];

    always_comb begin
        fsm_d = fsm_q;
        hp_d  = hp_q;
        cnt_d = cnt_q;
        ack_d = 1'b0;

        if (restart) begin
            // Restart wins over hit/heal and ignores the game state.
            fsm_d = ST_ALIVE;
            hp_d  = HP_MAX;
            cnt_d = 7'd0;
        end else if (battle) begin
            case (fsm_q)
                ST_ALIVE: begin
                    if (hit) begin
                        // A same-cycle heal is dropped in favour of the hit.
                        hp_d  = hp_damaged;
                        ack_d = 1'b1;
                        if (hp_damaged == 10'd0) begin
                            fsm_d = ST_DEAD;
                            cnt_d = 7'd0;
                        end else begin
                            fsm_d = ST_INVULN;
                            cnt_d = IFRAME_TICKS;
                        end
                    end else if (heal_req) begin
                        hp_d = hp_healed;
                    end
                end
                ST_INVULN: begin
                    // Hits are ignored here, so a concurrent heal still lands.
                    if (heal_req) begin
                        hp_d = hp_healed;
                    end
                    if (frame_tick) begin
                        if (cnt_q <= 7'd1) begin
                            fsm_d = ST_ALIVE;
                            cnt_d = 7'd0;
                        end else begin
                            cnt_d = cnt_q - 7'd1;
                        end
                    end
                end
                ST_DEAD: begin
                    hp_d = 10'd0;
                end
                default: begin
                    fsm_d = ST_ALIVE;
                    cnt_d = 7'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= ST_ALIVE;
            hp_q  <= HP_MAX;
            cnt_q <= 7'd0;
            ack_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            hp_q  <= hp_d;
            cnt_q <= cnt_d;
            ack_q <= ack_d;
        end
    end

    assign hp      = hp_q;
    assign dead    = (fsm_q == ST_DEAD);
    assign invuln  = (fsm_q == ST_INVULN);
    assign hit_ack = ack_q;

endmodule

// File: tb/tb_hp_controller.sv
// Directed self-checking bench for hp_controller.
module tb_hp_controller;

    logic       clk;
    logic       reset;
    logic [3:0] state;
    logic       frame_tick;
    logic       hit;
    logic       heal_req;
    logic       restart;
    logic [9:0] hp;
    logic       dead;
    logic       invuln;
    logic       hit_ack;

    int n_cmp  = 0;
    int n_fail = 0;
    int acks;

    hp_controller dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .frame_tick (frame_tick),
        .hit        (hit),
        .heal_req   (heal_req),
        .restart    (restart),
        .hp         (hp),
        .dead       (dead),
        .invuln     (invuln),
        .hit_ack    (hit_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let a full invincibility window run out with a tick every cycle.
    task automatic expire();
        frame_tick = 1'b1;
        repeat (60) step();
        frame_tick = 1'b0;
    endtask

    task automatic hit_and_expire();
        hit = 1'b1;
        step();
        hit = 1'b0;
        expire();
    endtask

    initial begin
        reset = 1'b1; state = 4'd0; frame_tick = 1'b0;
        hit = 1'b0; heal_req = 1'b0; restart = 1'b0;
        #1;
        check("rst_hp", hp, 200);
        check("rst_dead", dead, 0);
        check("rst_invuln", invuln, 0);
        check("rst_ack", hit_ack, 0);
        step();
        reset = 1'b0;

        // Single hit, then exactly 60 ticks of invincibility.
        state = 4'd1;
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("hit1_hp", hp, 180);
        check("hit1_ack", hit_ack, 1);
        check("hit1_invuln", invuln, 1);
        step();
        check("hit1_ack_pulse", hit_ack, 0);
        frame_tick = 1'b1;
        repeat (59) step();
        check("iframe_59", invuln, 1);
        step();
        check("iframe_60", invuln, 0);
        check("iframe_hp", hp, 180);
        frame_tick = 1'b0;

        // Held hit: ignored during iframes, re-applied once they expire.
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_hp", hp, 200);
        hit = 1'b1;
        step();
        check("held_first_hp", hp, 180);
        acks = 0;
        repeat (100) begin
            step();
            if (hit_ack) acks++;
        end
        check("held_hp", hp, 180);
        check("held_acks", acks, 0);
        expire();
        check("held_expired_invuln", invuln, 0);
        check("held_expired_hp", hp, 180);
        step();
        hit = 1'b0;
        check("held_rehit_hp", hp, 160);
        check("held_rehit_ack", hit_ack, 1);
        check("held_rehit_invuln", invuln, 1);

        // Heal clamps at full HP.
        restart = 1'b1;
        step();
        restart = 1'b0;
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("pre_heal_hp", hp, 180);
        heal_req = 1'b1;
        step();
        heal_req = 1'b0;
        check("heal_clamp_hp", hp, 200);
        check("heal_keeps_invuln", invuln, 1);
        expire();
        repeat (5) hit_and_expire();
        check("five_hits_hp", hp, 100);
        check("five_hits_alive", invuln, 0);

        // Hit + heal together: ALIVE takes the hit, INVULN takes the heal.
        hit = 1'b1;
        heal_req = 1'b1;
        step();
        check("both_alive_hp", hp, 80);
        check("both_alive_ack", hit_ack, 1);
        step();
        hit = 1'b0;
        heal_req = 1'b0;
        check("both_invuln_hp", hp, 120);
        check("both_invuln_ack", hit_ack, 0);
        expire();
        hit_and_expire();
        check("pre_heal2_hp", hp, 100);
        heal_req = 1'b1;
        step();
        heal_req = 1'b0;
        check("heal_plain_hp", hp, 140);

        // Outside battle nothing moves, including the iframe counter.
        hit = 1'b1;
        step();
        check("nb_pre_hp", hp, 120);
        state = 4'd0;
        heal_req = 1'b1;
        frame_tick = 1'b1;
        acks = 0;
        repeat (70) begin
            step();
            if (hit_ack) acks++;
        end
        hit = 1'b0;
        heal_req = 1'b0;
        check("nb_hp", hp, 120);
        check("nb_invuln", invuln, 1);
        check("nb_acks", acks, 0);
        state = 4'd2;
        repeat (59) step();
        check("nb_cnt_59", invuln, 1);
        step();
        check("nb_cnt_60", invuln, 0);
        frame_tick = 1'b0;

        // Asynchronous reset mid-INVULN.
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("pre_arst_hp", hp, 100);
        check("pre_arst_invuln", invuln, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_hp", hp, 200);
        check("arst_invuln", invuln, 0);
        step();
        reset = 1'b0;

        // Death at the exact-damage boundary, then DEAD ignores everything.
        repeat (9) hit_and_expire();
        check("pre_death_hp", hp, 20);
        hit = 1'b1;
        step();
        check("death_hp", hp, 0);
        check("death_dead", dead, 1);
        check("death_ack", hit_ack, 1);
        check("death_invuln", invuln, 0);
        heal_req = 1'b1;
        frame_tick = 1'b1;
        step();
        step();
        check("dead_hp", hp, 0);
        check("dead_dead", dead, 1);
        check("dead_ack", hit_ack, 0);

        // Restart outranks hit/heal and works outside battle.
        state = 4'd0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        hit = 1'b0;
        heal_req = 1'b0;
        frame_tick = 1'b0;
        check("revive_hp", hp, 200);
        check("revive_dead", dead, 0);
        check("revive_ack", hit_ack, 0);
        check("revive_invuln", invuln, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
